// File: rtl/circbuf_ctl_pkg.sv
// Shared configuration, state encoding and helpers for the circular-buffer flow controller.
// The sizing constants here fix the buffer geometry for every file in the slice.
package circbuf_ctl_pkg;

    localparam int DEPTH     = 16;
    localparam int INS_COUNT = 2;
    localparam int EXT_COUNT = 2;
    // One slot is sacrificed so that equal pointers always mean empty.
    localparam int CAP       = DEPTH - 1;
    localparam int ICW       = $clog2(INS_COUNT + 1);
    localparam int ECW       = $clog2(EXT_COUNT + 1);
    localparam int OCW       = $clog2(DEPTH);

    typedef enum logic {RUN, DRAIN} ctl_state_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/circbuf_ctl_if.sv
// Producer/consumer/buffer-side signal bundle of the flow controller.
// The controller binds to slave; the surrounding pipeline (or a bench) binds to master.
interface circbuf_ctl_if;
    import circbuf_ctl_pkg::*;

    logic [ICW-1:0]       prod_count;
    logic [ICW-1:0]       prod_accept;
    logic [ECW-1:0]       cons_ready;
    logic [EXT_COUNT-1:0] cons_valid;
    logic [ICW-1:0]       buf_new_count;
    logic [ECW-1:0]       buf_ext_consumed;
    logic                 flush;
    logic                 flush_busy;
    logic [OCW-1:0]       occupancy;

    modport slave (
        input  prod_count, cons_ready, flush,
        output prod_accept, cons_valid, buf_new_count, buf_ext_consumed, flush_busy, occupancy
    );

    modport master (
        output prod_count, cons_ready, flush,
        input  prod_accept, cons_valid, buf_new_count, buf_ext_consumed, flush_busy, occupancy
    );

endinterface

// File: rtl/circbuf_ctl_therm_mask.sv
// Count to thermometer mask: the lowest 'count' bits are set, bit 0 being the oldest slot.
module circbuf_ctl_therm_mask
    import circbuf_ctl_pkg::*;
(
    input  logic [ECW-1:0]       count,
    output logic [EXT_COUNT-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            mask[i] = (32'(count) > 32'(i));
        end
    end

endmodule

// File: rtl/circbuf_ctl.sv
// Flow controller for a multi-port circular buffer: grants inserts/extracts from a
// registered occupancy count and empties the buffer on flush by draining it.
module circbuf_ctl
    import circbuf_ctl_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    circbuf_ctl_if.slave bus
);

    // One spare bit so free/occupancy arithmetic never wraps.
    localparam int AW = OCW + 1;
    typedef logic [AW-1:0] cnt_t;

    ctl_state_t     state_q, state_d;
    logic [OCW-1:0] occupancy_q, occupancy_d;

    cnt_t pc, cr, occ, free;
    cnt_t accept, avail, consumed, remain;
    logic busy;

    always_comb begin
        pc   = cnt_t'(min_u(32'(bus.prod_count), INS_COUNT));
        cr   = cnt_t'(min_u(32'(bus.cons_ready), EXT_COUNT));
        occ  = cnt_t'(occupancy_q);
        free = cnt_t'(CAP) - occ;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            occupancy_q <= '0;
        end else begin
            state_q     <= state_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        remain  = occ - consumed;
        case (state_q)
            RUN:     if (bus.flush && (remain != '0)) state_d = DRAIN;
            DRAIN:   if (remain == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs: grants only in RUN without flush; any flush activity just drains.
    always_comb begin
        accept   = '0;
        avail    = '0;
        consumed = '0;
        busy     = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (bus.flush) begin
                        consumed = cnt_t'(min_u(32'(occ), EXT_COUNT));
                        busy     = 1'b1;
                    end else begin
                        accept   = cnt_t'(min_u(32'(pc), 32'(free)));
                        avail    = cnt_t'(min_u(32'(occ), EXT_COUNT));
                        consumed = cnt_t'(min_u(32'(cr), 32'(avail)));
                    end
                end
                DRAIN: begin
                    consumed = cnt_t'(min_u(32'(occ), EXT_COUNT));
                    busy     = 1'b1;
                end
                default: busy = 1'b0;
            endcase
        end
    end

    // Same-cycle extracts free space only next cycle: accept is bounded by registered free.
    always_comb begin
        occupancy_d = OCW'(occ + accept - consumed);
    end

    circbuf_ctl_therm_mask u_valid_mask (
        .count (avail[ECW-1:0]),
        .mask  (bus.cons_valid)
    );

    assign bus.prod_accept      = accept[ICW-1:0];
    assign bus.buf_new_count    = accept[ICW-1:0];
    assign bus.buf_ext_consumed = consumed[ECW-1:0];
    assign bus.flush_busy       = busy;
    assign bus.occupancy        = occupancy_q;

    a_occ_cap: assert property (@(posedge clock) occ <= cnt_t'(CAP));
    a_ext_le_occ: assert property (@(posedge clock) disable iff (reset) consumed <= occ);
    a_acc_le_offer: assert property (@(posedge clock) disable iff (reset)
                                     accept <= cnt_t'(bus.prod_count));

endmodule

// File: tb/tb_circbuf_ctl.sv
// Randomized and directed bench for circbuf_ctl against an occupancy-level reference model.
module tb_circbuf_ctl;
    import circbuf_ctl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    circbuf_ctl_if bus();

    circbuf_ctl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int  checks = 0;
    int  errors = 0;
    int  m_occ = 0;
    bit  m_drain = 1'b0;
    longint sum_new = 0;
    longint sum_cons = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare every output with the model, then advance the model.
    task automatic step(input int pc, input int cr, input bit fl, input bit rs);
        int  pcl, crl, e_acc, e_cv, e_cons, avail;
        bit  e_busy;
        @(posedge clock);
        #1;
        bus.prod_count = 2'(pc);
        bus.cons_ready = 2'(cr);
        bus.flush      = fl;
        reset          = rs;
        #2;
        pcl = imin(pc, INS_COUNT);
        crl = imin(cr, EXT_COUNT);
        e_acc = 0; e_cv = 0; e_cons = 0; e_busy = 1'b0;
        if (!rs) begin
            if (m_drain || fl) begin
                e_cons = imin(m_occ, EXT_COUNT);
                e_busy = 1'b1;
            end else begin
                e_acc  = imin(pcl, CAP - m_occ);
                avail  = imin(m_occ, EXT_COUNT);
                e_cv   = (1 << avail) - 1;
                e_cons = imin(crl, avail);
            end
        end
        chk("occupancy", int'(bus.occupancy), m_occ);
        chk("prod_accept", int'(bus.prod_accept), e_acc);
        chk("buf_new_count", int'(bus.buf_new_count), e_acc);
        chk("buf_ext_consumed", int'(bus.buf_ext_consumed), e_cons);
        chk("cons_valid", int'(bus.cons_valid), e_cv);
        chk("flush_busy", int'(bus.flush_busy), int'(e_busy));
        sum_new  += bus.buf_new_count;
        sum_cons += bus.buf_ext_consumed;
        if (rs) begin
            m_occ   = 0;
            m_drain = 1'b0;
        end else begin
            m_drain = e_busy && (m_occ - e_cons > 0);
            m_occ   = m_occ + e_acc - e_cons;
        end
    endtask

    int fill_exp[9] = '{2, 2, 2, 2, 2, 2, 2, 1, 0};
    int drain_exp[4] = '{2, 2, 2, 1};

    initial begin
        bus.prod_count = '0;
        bus.cons_ready = '0;
        bus.flush      = 1'b0;

        // Reset state and fill to capacity
        step(0, 0, 0, 1);
        step(2, 2, 1, 1);
        chk("reset_accept", int'(bus.prod_accept), 0);
        chk("reset_busy", int'(bus.flush_busy), 0);
        for (int i = 0; i < 9; i++) begin
            step(2, 0, 0, 0);
            chk("fill_accept", int'(bus.prod_accept), fill_exp[i]);
            if (i >= 1) chk("fill_valid", int'(bus.cons_valid), 3);
        end
        step(0, 0, 0, 0);
        chk("fill_occ", int'(bus.occupancy), 15);

        // Latency then steady wrap
        step(0, 0, 0, 1);
        sum_new = 0; sum_cons = 0;
        step(2, 2, 0, 0);
        chk("lat0_valid", int'(bus.cons_valid), 0);
        chk("lat0_consumed", int'(bus.buf_ext_consumed), 0);
        step(2, 2, 0, 0);
        chk("lat1_valid", int'(bus.cons_valid), 3);
        chk("lat1_consumed", int'(bus.buf_ext_consumed), 2);
        for (int i = 0; i < 99; i++) begin
            step(2, 2, 0, 0);
            chk("wrap_occ", int'(bus.occupancy), 2);
        end
        chk("wrap_sum", int'(sum_new - sum_cons), 2);

        // Clamp and partial accept
        step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(2, 0, 0, 0);
        step(3, 0, 0, 0);
        chk("clamp_accept", int'(bus.prod_accept), 1);
        for (int i = 0; i < 7; i++) step(0, 2, 0, 0);
        step(0, 3, 0, 0);
        chk("clamp_consumed", int'(bus.buf_ext_consumed), 1);
        chk("clamp_valid", int'(bus.cons_valid), 1);

        // Flush at occupancy 7
        for (int i = 0; i < 3; i++) step(2, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(2, 2, (i == 0), 0);
            chk("drain_consumed", int'(bus.buf_ext_consumed), drain_exp[i]);
            chk("drain_busy", int'(bus.flush_busy), 1);
            chk("drain_accept", int'(bus.prod_accept), 0);
            chk("drain_valid", int'(bus.cons_valid), 0);
        end
        step(2, 0, 0, 0);
        chk("drain_done_occ", int'(bus.occupancy), 0);
        chk("drain_done_busy", int'(bus.flush_busy), 0);
        chk("drain_done_accept", int'(bus.prod_accept), 2);

        // Flush while empty: single busy cycle
        step(0, 2, 0, 0);
        step(2, 0, 1, 0);
        chk("flush0_busy", int'(bus.flush_busy), 1);
        chk("flush0_accept", int'(bus.prod_accept), 0);
        step(0, 0, 0, 0);
        chk("flush0_after_busy", int'(bus.flush_busy), 0);

        // Reset in the second drain cycle
        for (int i = 0; i < 4; i++) step(2, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(2, 2, 0, 1);
        chk("rst_drain_consumed", int'(bus.buf_ext_consumed), 0);
        chk("rst_drain_busy", int'(bus.flush_busy), 0);
        chk("rst_drain_valid", int'(bus.cons_valid), 0);
        step(2, 0, 0, 0);
        chk("rst_after_occ", int'(bus.occupancy), 0);
        chk("rst_after_accept", int'(bus.prod_accept), 2);
        for (int i = 0; i < 8; i++) step(2, 0, 0, 0);

        // Random phases alternating producer-heavy and consumer-heavy traffic
        for (int blk = 0; blk < 40; blk++) begin
            int hi_p, hi_c;
            hi_p = (blk % 2 == 0) ? 3 : 1;
            hi_c = (blk % 2 == 0) ? 1 : 3;
            for (int i = 0; i < 50; i++) begin
                step(int'($urandom_range(0, hi_p)), int'($urandom_range(0, hi_c)),
                     ($urandom_range(0, 23) == 0), ($urandom_range(0, 299) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
